// File: rtl/sdlib_vc_pkg.sv
// sdlib_vc_pkg: link state encodings and wakeup handshake defaults shared by sd2vc and vc2sd
package sdlib_vc_pkg;
  typedef enum logic [1:0] {
    s_wake0 = 2'd0,
    s_wake1 = 2'd1,
    s_wait  = 2'd2,
    s_run   = 2'd3
  } vc_state_t;
  localparam int vc_wakeup_pattern = 1;
  localparam int vc_wake_gap = 16;
endpackage

// File: rtl/sd_credit_cnt.sv
// sd_credit_cnt: up/down credit counter saturating at depth with sticky overflow flag
module sd_credit_cnt #(
  parameter int depth = 16,
  parameter int csz = $clog2(depth + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc,
  input  logic           dec,
  output logic [csz-1:0] cnt,
  output logic           overflow
);
  logic full;
  assign full = cnt == csz'(depth);
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (full) overflow <= 1'b1;
      else cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/sd2vc.sv
// sd2vc: srdy/drdy to valid/credit transmit converter with post-reset wakeup handshake
module sd2vc
  import sdlib_vc_pkg::*;
#(
  parameter int depth = 16,
  parameter int csz = $clog2(depth + 1),
  parameter int width = 8,
  parameter int reginp = 0,
  parameter int wakeup_pattern = vc_wakeup_pattern,
  parameter int wake_gap = vc_wake_gap
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_vld,
  input  logic             p_cr,
  output logic [width-1:0] p_data,
  output logic             cr_overflow
);
  localparam int gsz = $clog2(wake_gap + 1);
  localparam logic [width-1:0] wpat = width'(wakeup_pattern);
  vc_state_t state;
  logic [gsz-1:0] gap;
  logic [csz-1:0] credits;
  logic cr_q, cr_eff, xfer;
  always_ff @(posedge clk)
    if (!reset) cr_q <= 1'b0;
    else cr_q <= p_cr;
  assign cr_eff = reginp != 0 ? cr_q : p_cr;
  // drdy comes only from flops so upstream never sees a path from p_cr or c_srdy
  assign c_drdy = state == s_run && credits != '0;
  assign xfer = c_srdy & c_drdy;
  sd_credit_cnt #(.depth(depth), .csz(csz)) u_cnt (
    .clk(clk),
    .reset(reset),
    .inc(cr_eff),
    .dec(xfer),
    .cnt(credits),
    .overflow(cr_overflow)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= s_wake0;
      gap <= '0;
      p_vld <= 1'b0;
      p_data <= '0;
    end else
      case (state)
        s_wake0: begin
          p_vld <= 1'b1;
          p_data <= wpat;
          state <= s_wake1;
        end
        s_wake1: begin
          p_vld <= 1'b1;
          p_data <= ~wpat;
          state <= s_wait;
          gap <= gsz'(wake_gap - 1);
        end
        s_wait: begin
          p_vld <= 1'b0;
          if (credits != '0) state <= s_run;
          else if (gap == '0) state <= s_wake0;
          else gap <= gap - 1'b1;
        end
        default: begin
          p_vld <= xfer;
          if (xfer) p_data <= c_data;
        end
      endcase
endmodule

// File: tb/tb_sd2vc.sv
// tb_sd2vc: randomized self-checking bench for sd2vc against a credit/word-count reference model
module tb_sd2vc;
  logic clk = 0, reset = 1, c_srdy = 0, p_cr = 0, r_cr = 0;
  logic [7:0] c_data = 0;
  logic c_drdy, p_vld, cr_overflow, r_drdy, r_vld, r_ovf;
  logic [7:0] p_data, r_data;
  int errors = 0, checks = 0;
  int m_cr;
  logic m_ovf, m_vld, m_run;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  sd2vc #(.depth(16), .width(8), .reginp(0), .wakeup_pattern(1), .wake_gap(4)) dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
    .p_vld(p_vld), .p_cr(p_cr), .p_data(p_data), .cr_overflow(cr_overflow)
  );
  sd2vc #(.depth(16), .width(8), .reginp(1), .wakeup_pattern(1), .wake_gap(4)) dut_r (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(r_drdy), .c_data(c_data),
    .p_vld(r_vld), .p_cr(r_cr), .p_data(r_data), .cr_overflow(r_ovf)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0; c_srdy = 0; p_cr = 0; r_cr = 0; c_data = 0;
    step;
    reset = 1;
    m_cr = 0; m_ovf = 0; m_vld = 0; m_data = 0; m_run = 0;
  endtask

  // one link cycle: words move only when linked and a credit is held
  task automatic cycle(input logic s, input logic [7:0] d, input logic cr);
    logic x;
    c_srdy = s; c_data = d; p_cr = cr;
    x = m_run && s && m_cr > 0;
    step;
    m_vld = x;
    if (x) m_data = d;
    m_cr = m_cr + int'(cr) - int'(x);
    if (m_cr > 16) begin
      m_cr = 16;
      m_ovf = 1;
    end
  endtask

  // credits returned during the wake words make the link run after the first wait cycle
  task automatic link_up(input int n);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, i < n);
    m_run = 1; m_vld = 0; m_data = 8'hFE;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (p_vld !== 0 || p_data !== 8'h00 || c_drdy !== 0 || cr_overflow !== 0)
      begin errors++; $display("FAIL reset: vld=%b data=%h drdy=%b ovf=%b want 0/00/0/0", p_vld, p_data, c_drdy, cr_overflow); end
  endtask

  task automatic test_wake;
    logic ev;
    logic [7:0] ed;
    do_reset;
    for (int i = 0; i < 14; i++) begin
      step;
      ev = (i % 6) < 2;
      ed = (i % 6 == 0) ? 8'h01 : 8'hFE;
      checks++;
      if (p_vld !== ev || p_data !== ed || c_drdy !== 0)
        begin errors++; $display("FAIL wake cyc %0d: vld=%b data=%h drdy=%b want %b/%h/0", i, p_vld, p_data, c_drdy, ev, ed); end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, pulses = 0;
    logic ex;
    do_reset;
    link_up(3);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (c_drdy !== (m_cr > 0)) begin errors++; $display("FAIL b2b drdy cyc %0d: got %b want %b", i, c_drdy, m_cr > 0); end
      ex = m_cr > 0;
      cycle(1, 8'hA0 + 8'(sent), 0);
      if (ex) sent++;
      if (p_vld === 1) pulses++;
      checks++;
      if (p_vld !== m_vld || p_data !== m_data)
        begin errors++; $display("FAIL b2b word cyc %0d: vld=%b data=%h want %b/%h", i, p_vld, p_data, m_vld, m_data); end
    end
    checks++;
    if (pulses !== 3 || c_drdy !== 0) begin errors++; $display("FAIL b2b count: words=%0d drdy=%b want 3/0", pulses, c_drdy); end
    cycle(1, 8'hA3, 1);
    checks++;
    if (c_drdy !== 1 || p_vld !== 0) begin errors++; $display("FAIL b2b credit: drdy=%b vld=%b want 1/0", c_drdy, p_vld); end
    cycle(1, 8'hA3, 0);
    checks++;
    if (p_vld !== 1 || p_data !== 8'hA3) begin errors++; $display("FAIL b2b fourth: vld=%b data=%h want 1/a3", p_vld, p_data); end
  endtask

  task automatic test_throughput;
    int pulses = 0;
    do_reset;
    link_up(3);
    for (int i = 0; i < 13; i++) cycle(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (c_drdy !== 1) begin errors++; $display("FAIL tput drdy cyc %0d: got %b want 1", i, c_drdy); end
      cycle(1, 8'($urandom), 1);
      checks++;
      if (p_vld !== 1 || p_data !== m_data) begin errors++; $display("FAIL tput word cyc %0d: vld=%b data=%h want 1/%h", i, p_vld, p_data, m_data); end
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'($urandom), 0);
      if (p_vld === 1) pulses++;
    end
    checks++;
    if (pulses !== 16 || cr_overflow !== 0 || c_drdy !== 0)
      begin errors++; $display("FAIL tput drain: words=%0d ovf=%b drdy=%b want 16/0/0", pulses, cr_overflow, c_drdy); end
  endtask

  task automatic test_overflow;
    int pulses = 0;
    do_reset;
    link_up(3);
    for (int i = 0; i < 13; i++) cycle(0, 8'h00, 1);
    checks++;
    if (cr_overflow !== 0) begin errors++; $display("FAIL ovf full: got %b want 0", cr_overflow); end
    cycle(0, 8'h00, 1);
    checks++;
    if (cr_overflow !== 1) begin errors++; $display("FAIL ovf set: got %b want 1", cr_overflow); end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'(i), 0);
      if (p_vld === 1) pulses++;
      checks++;
      if (cr_overflow !== 1) begin errors++; $display("FAIL ovf sticky cyc %0d: got %b want 1", i, cr_overflow); end
    end
    checks++;
    if (pulses !== 16) begin errors++; $display("FAIL ovf saturate: words=%0d want 16", pulses); end
    do_reset;
    checks++;
    if (cr_overflow !== 0) begin errors++; $display("FAIL ovf clear: got %b want 0", cr_overflow); end
  endtask

  task automatic test_random;
    do_reset;
    link_up(1);
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (c_drdy !== (m_cr > 0)) begin errors++; $display("FAIL rand drdy cyc %0d: got %b want %b", i, c_drdy, m_cr > 0); end
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if (p_vld !== m_vld || p_data !== m_data || cr_overflow !== m_ovf)
        begin errors++; $display("FAIL rand cyc %0d: vld=%b data=%h ovf=%b want %b/%h/%b", i, p_vld, p_data, cr_overflow, m_vld, m_data, m_ovf); end
    end
  endtask

  task automatic test_mid_reset;
    do_reset;
    link_up(3);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 1);
    cycle(1, 8'h5A, 1);
    checks++;
    if (m_cr !== 5 || p_vld !== 1 || p_data !== 8'h5A) begin errors++; $display("FAIL midrst pre: vld=%b data=%h want 1/5a", p_vld, p_data); end
    reset = 0; p_cr = 0;
    step;
    checks++;
    if (p_vld !== 0 || p_data !== 8'h00 || c_drdy !== 0 || cr_overflow !== 0)
      begin errors++; $display("FAIL midrst values: vld=%b data=%h drdy=%b ovf=%b want 0/00/0/0", p_vld, p_data, c_drdy, cr_overflow); end
    reset = 1;
    step;
    checks++;
    if (p_vld !== 1 || p_data !== 8'h01) begin errors++; $display("FAIL midrst wake0: vld=%b data=%h want 1/01", p_vld, p_data); end
    step;
    checks++;
    if (p_vld !== 1 || p_data !== 8'hFE) begin errors++; $display("FAIL midrst wake1: vld=%b data=%h want 1/fe", p_vld, p_data); end
    step;
    step;
    checks++;
    if (p_vld !== 0 || c_drdy !== 0) begin errors++; $display("FAIL midrst credits: vld=%b drdy=%b want 0/0", p_vld, c_drdy); end
  endtask

  task automatic test_reginp;
    do_reset;
    r_cr = 1;
    step;
    r_cr = 0;
    step;
    step;
    checks++;
    if (r_drdy !== 1) begin errors++; $display("FAIL reginp link: drdy=%b want 1", r_drdy); end
    c_srdy = 1; c_data = 8'h3C;
    step;
    checks++;
    if (r_vld !== 1 || r_data !== 8'h3C || r_drdy !== 0)
      begin errors++; $display("FAIL reginp word: vld=%b data=%h drdy=%b want 1/3c/0", r_vld, r_data, r_drdy); end
    r_cr = 1;
    step;
    r_cr = 0;
    checks++;
    if (r_drdy !== 0) begin errors++; $display("FAIL reginp early: drdy=%b want 0", r_drdy); end
    step;
    checks++;
    if (r_drdy !== 1) begin errors++; $display("FAIL reginp late: drdy=%b want 1", r_drdy); end
  endtask

  initial begin
    test_reset;
    test_wake;
    test_back_to_back;
    test_throughput;
    test_overflow;
    test_random;
    test_mid_reset;
    test_reginp;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd2vc.md
# sd2vc

Srdy/drdy-to-valid/credit converter: the transmit half of a valid/credit link whose receive half is the team's vc2sd block. Accepts words from an upstream srdy/drdy producer and forwards each as a single-cycle valid pulse, only while it holds a credit returned by the far end. After reset it sends the wakeup handshake (pattern, then its inverse) until the far end starts returning credits. All link-side outputs are registered.

## Interface
- `depth`, 16: far-end FIFO depth; maximum credits held.
- `csz`, $clog2(depth+1): credit counter width.
- `width`, 8: data width.
- `reginp`, 0: 1 = register `p_cr` before use; adds one cycle of credit latency.
- `wakeup_pattern`, 1: handshake word, truncated to `width` bits.
- `wake_gap`, 16: idle cycles between handshake attempts, ≥1.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset (`reset==0` resets on the `clk` rising edge).
- `c_srdy`  in  1  upstream word valid.
- `c_drdy`  out  1  block accepts word this cycle.
- `c_data`  in  width  upstream data.
- `p_vld`  out  1  link valid, one cycle per word.
- `p_cr`  in  1  link credit return, one credit per asserted cycle.
- `p_data`  out  width  link data.
- `cr_overflow`  out  1  sticky error: credit received with counter at `depth`.

## Operation
- States: `s_wake0`, `s_wake1`, `s_wait`, `s_run`. Reset enters `s_wake0`.
- `s_wake0`: drive `p_vld=1`, `p_data=wakeup_pattern`; next state `s_wake1`.
- `s_wake1`: drive `p_vld=1`, `p_data=~wakeup_pattern` (width bits); next state `s_wait`, gap counter loaded with `wake_gap-1`.
- `s_wait`: `p_vld=0`. Credit count ≠0 → `s_run`; else gap counter 0 → `s_wake0`; else decrement.
- `s_run`: `c_drdy = (credits != 0)`. Transfer on `c_srdy & c_drdy`: next cycle `p_vld=1`, `p_data=c_data`, credits −1.
- Credit counter: +1 per effective `p_cr`, −1 per transfer; both in the same cycle → unchanged. Credits are counted in every state, including wake states.
- Counter at `depth` and credit arrives without a simultaneous transfer: counter saturates at `depth`, `cr_overflow` set until reset.
- Counter never decrements below 0: `c_drdy` is 0 whenever credits==0.
- `c_drdy` is 0 in all states except `s_run`.
- Handshake words are never consumed from upstream and never use credits.
- `p_data` holds its last value when `p_vld=0`.
- Far-end reset while this block is in `s_run` is unsupported; both ends are reset together.

## Timing
- Reset values: `p_vld=0`, `p_data=0`, `c_drdy=0`, `cr_overflow=0`, credits 0, gap counter 0, state `s_wake0`.
- First cycle after reset release: `p_vld=1` with the pattern. Second cycle: the inverse.
- Data latency: transfer accepted in cycle N → `p_vld`/`p_data` registered out in cycle N+1.
- Credit latency: `p_cr` in cycle N → counter updated at N+1 (reginp=0) or N+2 (reginp=1). `c_drdy` can rise in the same cycle the counter update is visible.
- `c_drdy` is a function of flops only (state, counter). It has no combinational path from `p_cr` or `c_srdy`.
- Sustained throughput of 1 word/cycle whenever credits ≥1 are continuously replenished.

## Structure
- Shared package `sdlib_vc_pkg`: the state encodings (`s_wake0`=0, `s_wake1`=1, `s_wait`=2, `s_run`=3) and the link-handshake constants. The package is also used by vc2sd.
- One natural sub-module: `sd_credit_cnt` (up/down saturating counter with overflow flag, parameters `depth`, `csz`).
- The state machine, gap counter and output registers stay in `sd2vc`.

## Test plan
- Reset, no credits returned, `wake_gap=4` → `p_vld` pattern `1,1,0,0,0,0,1,1,…`. Data alternates 0x01/0xFE. `c_drdy` stays 0.
- Back-to-back pair: wakeup, then 3 `p_cr` pulses, `c_srdy` held with data 0xA0,0xA1,0xA2,0xA3 → exactly 3 words appear on `p_vld`. `c_drdy` falls after the third transfer. The 4th word is sent one cycle after the next `p_cr` (reginp=0).
- 16 credits, continuous `c_srdy` with one `p_cr` per cycle → 1 word/cycle, credit count constant at 16.
- 16 credits held, one extra `p_cr` with no transfer → `cr_overflow=1` next cycle, count stays 16. Flag remains 1 until `reset=0`.
- `reginp=1`: single `p_cr` in `s_run` with 0 credits → `c_drdy` rises 2 cycles later.
- Reset asserted mid-stream with credits=5 → next cycle all outputs at reset values. After release the wake sequence restarts.
